// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the instruction cache.
//   word_t          32-bit machine word
//   icachef_t       fetch address split {tag, idx, bytoff} for the default 16 sets
//   icache_frame_t  one cache frame {valid, tag, data} for the default 16 sets
//   icache_state_t  cache controller states HIT / MISS
// Optional feature macro used by the cache: ICACHE_FILL_FWD_EN.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int IBYT_W = 2;
    localparam int IIDX_W = 4;
    localparam int ITAG_W = 32 - IIDX_W - IBYT_W;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [IBYT_W-1:0] bytoff;
    } icachef_t;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        word_t             data;
    } icache_frame_t;

    typedef enum logic {
        HIT  = 1'b0,
        MISS = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_if.sv
// icache_if: fetch-port and memory-port signals of the instruction cache.
//   Datapath side : imemREN, imemaddr (to cache); ihit, imemload (from cache)
//   Memory side   : iREN, iaddr (from cache); iwait, iload (to cache)
// Modports: slave = the cache itself, master = datapath plus memory_control.
interface icache_if;
    import cpu_types_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache_frames.sv
// icache_frames: SETS-entry frame store of the instruction cache.
//   CLK, nRST       clock, asynchronous active-low reset (clears valid bits only)
//   rd_idx_i        lookup index; rd_valid_o/rd_tag_o/rd_data_o read asynchronously
//   wr_en_i         write one frame on the rising edge: valid=1, wr_tag_i, wr_data_i
//   wr_idx_i        frame to write
module icache_frames
    import cpu_types_pkg::*;
#(
    parameter int SETS   = 16,
    parameter int IDX_W  = $clog2(SETS),
    parameter int TAG_W  = 30 - IDX_W
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output word_t            rd_data_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  word_t            wr_data_i
);
    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_mem [SETS];
    word_t            data_mem [SETS];

    // Valid bits are individual flops so they can be cleared by reset;
    // tag and data live in plain arrays that never need clearing.
    genvar gi;
    generate
        for (gi = 0; gi < SETS; gi++) begin : g_valid
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    valid_q[gi] <= 1'b0;
                end else if (wr_en_i && (wr_idx_i == IDX_W'(gi))) begin
                    valid_q[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (wr_en_i) begin
            tag_mem[wr_idx_i]  <= wr_tag_i;
            data_mem[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_mem[rd_idx_i];
    assign rd_data_o  = data_mem[rd_idx_i];
endmodule

// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-block instruction cache for one core.
//   CLK   clock, rising edge
//   nRST  asynchronous active-low reset
//   bus   icache_if.slave: imemREN/imemaddr in, ihit/imemload out (datapath),
//         iREN/iaddr out, iwait/iload in (memory_control)
// Hits are served combinationally. A miss holds iREN/iaddr until iwait drops,
// then writes the frame. Define ICACHE_FILL_FWD_EN to also return the fill word
// to the datapath in the fill cycle when it is still asking for that address.
module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int CPUID = 0
) (
    input logic     CLK,
    input logic     nRST,
    icache_if.slave bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    generate
        if (SETS < 2 || (SETS & (SETS - 1)) != 0 || CPUID < 0) begin : g_bad_cfg
            $error("icache: SETS must be a power of two >= 2 and CPUID non-negative");
        end
    endgenerate

    icache_state_t     state_q, state_d;
    logic [29:0]       missaddr_q, missaddr_d;   // word address of the pending miss

    logic [IDX_W-1:0]  lookup_idx;
    logic [TAG_W-1:0]  lookup_tag;
    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    word_t             rd_data;
    logic              lookup_hit;
    logic              fill_en;

    logic              ihit_c;
    word_t             imemload_c;
    logic              iren_c;
    word_t             iaddr_c;

    assign lookup_idx = bus.imemaddr[IDX_W+1:2];
    assign lookup_tag = bus.imemaddr[31:IDX_W+2];
    assign lookup_hit = rd_valid && (rd_tag == lookup_tag);

    icache_frames #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_frames (
        .CLK        (CLK),
        .nRST       (nRST),
        .rd_idx_i   (lookup_idx),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .wr_en_i    (fill_en),
        .wr_idx_i   (missaddr_q[IDX_W-1:0]),
        .wr_tag_i   (missaddr_q[29:IDX_W]),
        .wr_data_i  (bus.iload)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= HIT;
            missaddr_q <= '0;
        end else begin
            state_q    <= state_d;
            missaddr_q <= missaddr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        missaddr_d = missaddr_q;
        ihit_c     = 1'b0;
        imemload_c = '0;
        iren_c     = 1'b0;
        iaddr_c    = '0;
        fill_en    = 1'b0;
        case (state_q)
            HIT: begin
                if (bus.imemREN) begin
                    if (lookup_hit) begin
                        ihit_c     = 1'b1;
                        imemload_c = rd_data;
                    end else begin
                        missaddr_d = bus.imemaddr[31:2];
                        state_d    = MISS;
                    end
                end
            end
            MISS: begin
                // The request is held to completion even if the datapath
                // redirects, since memory_control expects it to stay up.
                iren_c  = 1'b1;
                iaddr_c = {missaddr_q, 2'b00};
                if (!bus.iwait) begin
                    fill_en = 1'b1;
                    state_d = HIT;
`ifdef ICACHE_FILL_FWD_EN
                    if (bus.imemREN && (bus.imemaddr[31:2] == missaddr_q)) begin
                        ihit_c     = 1'b1;
                        imemload_c = bus.iload;
                    end
`endif
                end
            end
            default: state_d = HIT;
        endcase
    end

    assign bus.ihit     = ihit_c;
    assign bus.imemload = imemload_c;
    assign bus.iREN     = iren_c;
    assign bus.iaddr    = iaddr_c;
endmodule

// File: tb/tb_icache.sv
module tb_icache;
    import cpu_types_pkg::*;

    typedef struct packed {
        logic  ihit;
        word_t imemload;
        logic  iren;
        word_t iaddr;
    } exp_t;

    logic CLK;
    logic nRST;
    icache_if bus ();

    icache #(.SETS(16), .CPUID(0)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int   n_vec;
    int   n_bad;
    exp_t exp_q [$];

    // Reference model state
    logic        m_state;          // 0 = looking up, 1 = waiting on memory
    logic [29:0] m_miss;
    logic        m_valid [16];
    logic [25:0] m_tag   [16];
    word_t       m_data  [16];

    task automatic check_val(input string tag, input word_t obs, input word_t want);
        n_vec++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h want %h", tag, $time, obs, want);
        end
    endtask

    function automatic word_t mem_word(input logic [29:0] w);
        word_t a;
        a = {w, 2'b00};
        case (a)
            32'h0000_0000: return 32'hDEAD_BEEF;
            32'h0000_0004: return 32'h1111_1111;
            32'h0000_0044: return 32'h2222_2222;
            default:       return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 1'b0;
        m_miss  = '0;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    // One clock cycle: drive, predict, compare mid-cycle, advance the model.
    task automatic step(input logic ren, input word_t addr, input logic wt);
        exp_t e;
        exp_t got;
        int   i;
        logic hit;
        bus.imemREN  = ren;
        bus.imemaddr = addr;
        bus.iwait    = wt;
        bus.iload    = mem_word(m_miss);
        i   = int'(addr[5:2]);
        hit = 1'b0;
        e   = '0;
        if (m_state) begin
            e.iren  = 1'b1;
            e.iaddr = {m_miss, 2'b00};
`ifdef ICACHE_FILL_FWD_EN
            if (!wt && ren && addr[31:2] == m_miss) begin
                e.ihit     = 1'b1;
                e.imemload = mem_word(m_miss);
            end
`endif
        end else begin
            hit = ren && m_valid[i] && (m_tag[i] == addr[31:6]);
            if (hit) begin
                e.ihit     = 1'b1;
                e.imemload = m_data[i];
            end
        end
        exp_q.push_back(e);

        @(negedge CLK);
        got = exp_q.pop_front();
        check_val("ihit",     {31'b0, bus.ihit}, {31'b0, got.ihit});
        check_val("imemload", bus.imemload,      got.imemload);
        check_val("iREN",     {31'b0, bus.iREN}, {31'b0, got.iren});
        check_val("iaddr",    bus.iaddr,         got.iaddr);
        $display("cyc addr=%h ren=%0b iwait=%0b -> ihit=%0b load=%h iREN=%0b iaddr=%h",
                 addr, ren, wt, bus.ihit, bus.imemload, bus.iREN, bus.iaddr);

        @(posedge CLK);
        if (m_state) begin
            if (!wt) begin
                m_valid[m_miss[3:0]] = 1'b1;
                m_tag[m_miss[3:0]]   = m_miss[29:4];
                m_data[m_miss[3:0]]  = mem_word(m_miss);
                m_state              = 1'b0;
            end
        end else if (ren && !hit) begin
            m_miss  = addr[31:2];
            m_state = 1'b1;
        end
        #1;
    endtask

    // Fetch one address; if it misses, hold iwait high for 'waits' cycles,
    // fill, then fetch once more.
    task automatic fetch(input word_t addr, input int waits);
        step(1'b1, addr, 1'b1);
        if (m_state) begin
            repeat (waits) step(1'b1, addr, 1'b1);
            step(1'b1, addr, 1'b0);
            step(1'b1, addr, 1'b1);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        nRST         = 1'b0;
        bus.imemREN  = 1'b0;
        bus.imemaddr = '0;
        bus.iwait    = 1'b1;
        bus.iload    = '0;
        model_reset();

        repeat (2) @(posedge CLK);
        #1;
        check_val("rst_ihit",     {31'b0, bus.ihit}, 32'd0);
        check_val("rst_imemload", bus.imemload,      32'd0);
        check_val("rst_iREN",     {31'b0, bus.iREN}, 32'd0);
        check_val("rst_iaddr",    bus.iaddr,         32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // Cold miss with three wait cycles, then a hit.
        fetch(32'h0000_0000, 3);
        // Two refetches hit in the same cycle.
        step(1'b1, 32'h0000_0000, 1'b1);
        step(1'b1, 32'h0000_0000, 1'b1);
        // Idle request: no hit, iwait ignored.
        step(1'b0, 32'h0000_0000, 1'b0);

        // Conflict on index 1.
        fetch(32'h0000_0004, 1);
        fetch(32'h0000_0044, 2);
        fetch(32'h0000_0004, 0);

        // Redirect mid-miss: 0x100 must still fill, then 0x200 misses.
        step(1'b1, 32'h0000_0100, 1'b1);
        step(1'b1, 32'h0000_0200, 1'b1);
        step(1'b1, 32'h0000_0200, 1'b1);
        step(1'b1, 32'h0000_0200, 1'b0);
        fetch(32'h0000_0200, 1);
        fetch(32'h0000_0100, 0);

        // Reset during a miss on 0x08.
        step(1'b1, 32'h0000_0008, 1'b1);
        step(1'b1, 32'h0000_0008, 1'b1);
        bus.imemREN = 1'b0;
        nRST = 1'b0;
        #1;
        check_val("rstmiss_iREN",  {31'b0, bus.iREN}, 32'd0);
        check_val("rstmiss_iaddr", bus.iaddr,         32'd0);
        model_reset();
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        fetch(32'h0000_0008, 1);
        // Earlier contents were invalidated by the reset.
        fetch(32'h0000_0000, 0);

        // Byte offset ignored.
        fetch(32'h0000_0010, 1);
        step(1'b1, 32'h0000_0013, 1'b1);
        step(1'b1, 32'h0000_0011, 1'b1);

        // A scattered sweep, including aliases of filled frames.
        for (int k = 0; k < 12; k++) begin
            fetch({22'h0, $urandom_range(0, 3) == 0 ? 2'b01 : 2'b00, $urandom_range(0, 63), 2'b00}, $urandom_range(0, 3));
        end

        check_val("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
